// File: rtl/ram_initiator.sv
// Host-side initiator for an asynchronous-read RAM: sequences SETUP/ACCESS/HOLD
// strobe phases per beat and runs incrementing read bursts with address wrap.
module ram_initiator #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 8,
    parameter int WAIT_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [3:0]        req_len,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_in,
    output logic              we,
    output logic              re,
    input  logic [DATA_W-1:0] data_out,
    output logic [1:0]        dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_M1 = 4'(WAIT_CYC - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              is_wr_q, is_wr_d;
    logic [3:0]        len_q, len_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            is_wr_q      <= 1'b0;
            len_q        <= '0;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            is_wr_q      <= is_wr_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        is_wr_d      = is_wr_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        resp_valid_d = 1'b0;
        rdata_d      = rdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    state_d = SETUP;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    is_wr_d = req_we;
                    // Writes are always a single beat regardless of req_len.
                    len_d   = req_we ? 4'd0 : req_len;
                end
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = WAIT_M1;
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = HOLD;
                    if (!is_wr_q) begin
                        resp_valid_d = 1'b1;
                        rdata_d      = data_out;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                if (len_q != 4'd0) begin
                    state_d = SETUP;
                    len_d   = len_q - 4'd1;
                    addr_d  = addr_q + 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready   = (state_q == IDLE) && !rst;
    assign busy        = (state_q != IDLE);
    assign we          = (state_q == ACCESS) && is_wr_q;
    assign re          = (state_q == ACCESS) && !is_wr_q;
    assign addr        = addr_q;
    assign data_in     = wdata_q;
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = rdata_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ram_initiator.sv
// Directed bench for ram_initiator: default instance (WAIT_CYC=1) plus a WAIT_CYC=3
// instance, each attached to a small asynchronous-read RAM model.
module tb_ram_initiator;

  localparam int AW = 10;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_q[$];

  // default instance signals
  logic          req_valid, req_ready, req_we, resp_valid, busy, we, re;
  logic [AW-1:0] req_addr, addr;
  logic [DW-1:0] req_wdata, resp_rdata, data_in, data_out;
  logic [3:0]    req_len;
  logic [1:0]    dbg_state;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  // WAIT_CYC=3 instance signals
  logic          r3_valid, r3_ready, r3_we, r3_resp_valid, r3_busy, r3_wen, r3_ren;
  logic [AW-1:0] r3_addr_in, r3_addr;
  logic [DW-1:0] r3_wdata, r3_rdata, r3_data_in, r3_data_out;
  logic [3:0]    r3_len;
  logic [1:0]    r3_state;
  logic [DW-1:0] mem3 [0:(1<<AW)-1];

  always #5 clk = ~clk;

  ram_initiator dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .busy(busy), .addr(addr), .data_in(data_in), .we(we), .re(re),
    .data_out(data_out), .dbg_state_o(dbg_state)
  );

  ram_initiator #(.WAIT_CYC(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(r3_valid), .req_ready(r3_ready), .req_we(r3_we),
    .req_addr(r3_addr_in), .req_wdata(r3_wdata), .req_len(r3_len), .resp_valid(r3_resp_valid),
    .resp_rdata(r3_rdata), .busy(r3_busy), .addr(r3_addr), .data_in(r3_data_in), .we(r3_wen),
    .re(r3_ren), .data_out(r3_data_out), .dbg_state_o(r3_state)
  );

  // RAM models: synchronous write, asynchronous read while re is high
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= data_in;
    if (r3_wen) mem3[r3_addr] <= r3_data_in;
  end
  assign data_out    = re ? mem[addr] : '0;
  assign r3_data_out = r3_ren ? mem3[r3_addr] : '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Present a request at a negedge; returns just after the accepting edge.
  task automatic start_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [3:0] len, input bit keep);
    @(negedge clk);
    check("ready_before_accept", req_ready, 1);
    req_we = w; req_addr = a; req_wdata = d; req_len = len; req_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!keep) req_valid = 1'b0;
  endtask

  // Cycle-accurate check of n read beats at WAIT_CYC=1, data from exp_q.
  task automatic read_beats(input logic [AW-1:0] start, input int n);
    logic [AW-1:0] a;
    a = start;
    for (int b = 0; b < n; b++) begin
      @(negedge clk);
      check("setup_re", re, 0);
      check("setup_addr", addr, a);
      check("setup_ready", req_ready, 0);
      @(negedge clk);
      check("access_re", re, 1);
      check("access_we", we, 0);
      check("access_addr", addr, a);
      check("access_busy", busy, 1);
      @(negedge clk);
      check("hold_re", re, 0);
      check("hold_addr", addr, a);
      check("hold_resp_valid", resp_valid, 1);
      check("hold_rdata", resp_rdata, exp_q.pop_front());
      a = a + 1'b1;
    end
  endtask

  task automatic write_beat(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    check("wr_setup_we", we, 0);
    check("wr_setup_addr", addr, a);
    check("wr_setup_data", data_in, d);
    @(negedge clk);
    check("wr_access_we", we, 1);
    check("wr_access_re", re, 0);
    check("wr_access_addr", addr, a);
    check("wr_access_data", data_in, d);
    @(negedge clk);
    check("wr_hold_we", we, 0);
    check("wr_hold_resp_valid", resp_valid, 0);
    check("wr_hold_busy", busy, 1);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = '0;
      mem3[i] = '0;
    end
    mem[1022] = 8'h11;
    mem[1023] = 8'h22;
    mem[5]    = 8'h33;
    mem[6]    = 8'h44;
    mem3[10]  = 8'h7E;
    rst = 1'b1;
    req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_len = '0;
    r3_valid = 0; r3_we = 0; r3_addr_in = '0; r3_wdata = '0; r3_len = '0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_we_re", {we, re}, 0);
    check("rst_addr", addr, 0);
    check("rst_data_in", data_in, 0);
    check("rst_resp", {resp_valid, resp_rdata}, 0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", req_ready, 1);

    // write 0xA9 to 0, then 0x02 to 1
    start_req(1'b1, 10'd0, 8'hA9, 4'd5, 1'b0);
    write_beat(10'd0, 8'hA9);
    @(negedge clk);
    check("wr_idle_ready", req_ready, 1);
    check("wr_idle_busy", busy, 0);
    start_req(1'b1, 10'd1, 8'h02, 4'd0, 1'b0);
    write_beat(10'd1, 8'h02);

    // single read of address 0
    exp_q.push_back(8'hA9);
    start_req(1'b0, 10'd0, 8'h00, 4'd0, 1'b0);
    read_beats(10'd0, 1);
    @(negedge clk);
    check("rd_idle_ready", req_ready, 1);
    check("rd_resp_pulse_end", resp_valid, 0);
    check("rd_rdata_held", resp_rdata, 8'hA9);

    // wrapping burst 1022,1023,0,1
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'hA9);
    exp_q.push_back(8'h02);
    start_req(1'b0, 10'd1022, 8'h00, 4'd3, 1'b0);
    read_beats(10'd1022, 4);
    @(negedge clk);
    check("burst_idle_ready", req_ready, 1);
    check("burst_rdata_held", resp_rdata, 8'h02);

    // req_valid held through a 2-beat burst; fields change after acceptance
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h44);
    start_req(1'b0, 10'd5, 8'h00, 4'd1, 1'b1);
    req_we = 1'b1; req_addr = 10'd7; req_wdata = 8'h5C; req_len = 4'd0;
    read_beats(10'd5, 2);
    @(negedge clk);
    check("b2b_ready", req_ready, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    write_beat(10'd7, 8'h5C);
    @(negedge clk);
    check("b2b_idle_ready", req_ready, 1);
    check("b2b_mem_written", mem[7], 8'h5C);

    // WAIT_CYC=3 read
    @(negedge clk);
    check("w3_ready", r3_ready, 1);
    r3_we = 1'b0; r3_addr_in = 10'd10; r3_len = 4'd0; r3_valid = 1'b1;
    @(posedge clk);
    #1;
    r3_valid = 1'b0;
    @(negedge clk);
    check("w3_setup_re", r3_ren, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("w3_access_re", r3_ren, 1);
      check("w3_access_resp", r3_resp_valid, 0);
    end
    @(negedge clk);
    check("w3_hold_re", r3_ren, 0);
    check("w3_resp_valid", r3_resp_valid, 1);
    check("w3_rdata", r3_rdata, 8'h7E);
    @(negedge clk);
    check("w3_idle_ready", r3_ready, 1);
    check("w3_resp_end", r3_resp_valid, 0);

    // reset during the ACCESS of the second beat of a burst
    exp_q.push_back(8'hA9);
    start_req(1'b0, 10'd0, 8'h00, 4'd3, 1'b0);
    read_beats(10'd0, 1);
    @(negedge clk);
    check("abort_setup_addr", addr, 1);
    @(negedge clk);
    check("abort_access_re", re, 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_we_re", {we, re}, 0);
    check("abort_busy", busy, 0);
    check("abort_ready_in_rst", req_ready, 0);
    check("abort_resp_valid", resp_valid, 0);
    check("abort_rdata", resp_rdata, 0);
    check("abort_addr", addr, 0);
    rst = 1'b0;
    #1;
    check("abort_ready_after_rst", req_ready, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("abort_no_resp", resp_valid, 0);
      check("abort_stays_idle", busy, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_initiator.md
RAM_INITIATOR -- requirements
Module: ram_initiator

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, RAM address width.
REQ-002 The block SHALL have parameter DATA_W, default 8, RAM data width.
REQ-003 The block SHALL have parameter WAIT_CYC, default 1, strobe-active cycles per access; legal range 1-15.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  host request present.
REQ-007 req_ready  output  1  block accepts a request this cycle.
REQ-008 req_we  input  1  1 = write, 0 = read.
REQ-009 req_addr  input  ADDR_W  start address.
REQ-010 req_wdata  input  DATA_W  write data.
REQ-011 req_len  input  4  read burst beats minus 1; ignored for writes.
REQ-012 resp_valid  output  1  one-cycle pulse; resp_rdata is valid.
REQ-013 resp_rdata  output  DATA_W  read data.
REQ-014 busy  output  1  transaction in progress.
REQ-015 addr  output  ADDR_W  RAM address.
REQ-016 data_in  output  DATA_W  RAM write data.
REQ-017 we, re  output  1 each  RAM write and read strobes.
REQ-018 data_out  input  DATA_W  RAM read data; asynchronous, valid while re is high.

Function
REQ-019 A request SHALL be accepted when req_valid and req_ready are both high at a clock edge; req_* fields are registered at that edge.
- req_ready SHALL be high only in IDLE with rst low.
- After acceptance, req_* changes SHALL have no effect.
REQ-020 FSM states SHALL be IDLE, SETUP, ACCESS, and HOLD.
- IDLE -> SETUP on accept.
- SETUP -> ACCESS after 1 cycle.
- ACCESS -> HOLD after WAIT_CYC cycles.
- HOLD -> SETUP if read beats remain; otherwise HOLD -> IDLE.
REQ-021 SETUP behaviour: addr and data_in SHALL be driven; we and re SHALL be 0.
REQ-022 ACCESS behaviour: we SHALL be 1 for a write, or re SHALL be 1 for a read; addr and data_in SHALL be held stable.
REQ-023 HOLD behaviour: we and re SHALL be 0 and addr SHALL be held.
REQ-024 we and re SHALL never be high in the same cycle.
REQ-025 Read capture and response:
- data_out SHALL be sampled into resp_rdata at the edge ending the last ACCESS cycle.
- resp_valid SHALL be 1 for exactly the following cycle (HOLD).
- The response has no backpressure.
REQ-026 Read burst:
- Total beats = req_len + 1.
- Each beat SHALL take WAIT_CYC + 2 cycles.
- addr SHALL increment by 1 per beat and wrap from 2^ADDR_W - 1 to 0.
REQ-027 A write SHALL be a single beat and SHALL produce no resp_valid.
REQ-028 Latency, with accept at edge T and WAIT_CYC = 1:
- SETUP in cycle T+1.
- Strobe high in T+2.
- HOLD, and resp_valid for a read, in T+3.
- req_ready high again in T+4.
REQ-029 busy SHALL equal NOT IDLE.
REQ-030 resp_rdata SHALL hold its last value until the next capture.

Reset
REQ-031 While rst is high at a clock edge, the block SHALL enter IDLE.
- Outputs: addr = 0, data_in = 0, we = 0, re = 0, resp_valid = 0, resp_rdata = 0, busy = 0.
- req_ready SHALL be 0 while rst is high.
REQ-032 Reset mid-transaction SHALL abort at the next edge: strobes drop, the burst is discarded, and no resp_valid is produced.
REQ-033 req_ready SHALL be 1 in the first cycle after rst falls.

Verification
REQ-034 Write 0xA9 to address 0 -> one cycle with we=1, addr=0, data_in=0xA9; re stays 0; no resp_valid.
REQ-035 Write 0x02 to address 1, then read address 0 against a RAM model -> resp_valid pulse at T+3 with resp_rdata = 0xA9.
REQ-036 Read burst with req_addr = 1022, req_len = 3 -> re pulses at addresses 1022, 1023, 0, 1, spaced 3 cycles apart; four resp_valid pulses with matching data.
REQ-037 WAIT_CYC = 3 read -> re high exactly 3 consecutive cycles; resp_valid in the cycle after the third.
REQ-038 req_valid held high during a burst -> no accept until IDLE; the second request starts at the first edge where req_ready = 1.
REQ-039 rst asserted during an ACCESS cycle of a burst -> we = re = 0 and busy = 0 at the next edge; no further resp_valid; req_ready = 1 one cycle after rst falls.
